aes_st_arbiter: RTL and testbench
=================================

# aes_st_arbiter

Packet-level round-robin arbiter that shares one Avalon-ST sink, the header adder input stream, between `NUM_SRC` Avalon-ST sources (word generators, host-injected messages). A grant is locked from start-of-packet to end-of-packet, so packets are never interleaved. Sources are served in rotating order. The block sits between the source streams and the header adder in the AES test top.

## Interface
Parameters:
- `NUM_SRC`, default 4: number of source streams, 2..8.
- `DATA_W`, default `REG_SIZE` (32): Avalon-ST data width.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `src_valid`  in  NUM_SRC  per-source valid.
- `src_sop`  in  NUM_SRC  per-source start of packet.
- `src_eop`  in  NUM_SRC  per-source end of packet.
- `src_data`  in  NUM_SRC×DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W].
- `src_ready`  out  NUM_SRC  per-source ready.
- `snk_valid`, `snk_sop`, `snk_eop`  out  1 each  sink stream controls.
- `snk_data`  out  DATA_W  sink data.
- `snk_ready`  in  1  sink backpressure.
- `grant`  out  $clog2(NUM_SRC)  currently or last granted source index.
- `busy`  out  1  high while in LOCKED.
- `pkt_cnt`  out  NUM_SRC×WORD_COUNTER_SIZE  per-source packet counts. Present only when `AES_ST_ARB_PKT_CNT_EN` is defined.

## Operation
- FSM with two states, IDLE and LOCKED. Reset state is IDLE.
- A source is a candidate when `src_valid[i] & src_sop[i]`.
- In IDLE, if any candidate exists:
  - Pick the first candidate searching upward from `last_grant+1`, modulo NUM_SRC.
  - Register it into `grant`.
  - Go to LOCKED.
- In IDLE, all `src_ready` bits are 0 and `snk_valid` is 0.
- In LOCKED, the sink is a combinational pass-through of `src[grant]`:
  - `snk_valid/sop/eop/data` equal the granted source's signals.
  - `src_ready[grant]` equals `snk_ready`.
  - All other `src_ready` bits are 0.
- A beat is accepted when `snk_valid & snk_ready`.
- An accepted beat with `eop=1` does three things: sets `last_grant <= grant`, moves the FSM to IDLE, and increments that source's packet counter if compiled in.
- A single-beat packet (`sop=eop=1`) is granted and released like any other packet.
- In IDLE, a source showing `valid` without `sop` is never a candidate. Its data is held off until it presents `sop`. This is protocol-error tolerance.
- In LOCKED, `src_valid[grant]=0` produces idle sink cycles. The lock is held with no timeout.
- `grant` holds its value in IDLE.

## Timing
- Arbitration costs 1 cycle. The first beat of a granted packet reaches the sink 1 cycle after the candidate first appears in IDLE.
- After an accepted eop there is 1 bubble cycle in IDLE, so the next packet's first beat appears 2 cycles after the eop beat.
- Steady-state throughput is 1 beat/cycle within a packet.
- Reset (asynchronous, any time, including mid-packet) forces:
  - FSM = IDLE, `grant=0`, `last_grant=NUM_SRC-1`, so source 0 has first priority.
  - `busy=0`, `src_ready=0`, `snk_valid=0`, `snk_sop=0`, `snk_eop=0`, `snk_data=0`.
  - `pkt_cnt=0`.
- An interrupted packet is not resumed. The source must restart it with `sop`.
- `pkt_cnt` wraps modulo 2^WORD_COUNTER_SIZE.

## Configuration
- `AES_ST_ARB_PKT_CNT_EN` defined: the `pkt_cnt` port and its counters exist. A counter updates the cycle after its eop is accepted.
- `AES_ST_ARB_PKT_CNT_EN` undefined: no counters and no `pkt_cnt` port. Arbitration behaviour is identical.

## Structure
- `aes_top_pack` holds:
  - the `arb_state_t` enum (IDLE, LOCKED);
  - `WORD_COUNTER_SIZE` and `REG_SIZE` (existing constants);
  - `ARB_MAX_SRC = 8`.
- One sub-module, `rr_priority_picker`: combinational, takes a request vector and the last index and returns a found flag and the next index. It is reusable by other arbiters.

## Test plan
- Reset with src0 showing `valid` and `sop`, then release → `snk_valid=1` with src0 data on the 2nd rising edge after release; `grant=0`, `busy=1`.
- All 4 sources send continuous 3-beat packets → grant order 0,1,2,3,0. No beats interleave within a packet, and each eop is followed by exactly 1 bubble cycle.
- src2 sends a single-beat packet (`sop=eop=1`, data `0xA5A5A5A5`) while the sink is ready → one sink beat with that data, then the FSM returns to IDLE; `last_grant=2`.
- `snk_ready` is low for 5 cycles mid-packet → `snk_data` stays stable, `src_ready[grant]=0`, and the other sources' ready stays 0 throughout.
- Assert `rst_n=0` asynchronously during beat 2 of a 4-beat packet from src1 → all outputs are immediately at reset values; src1 must resend with `sop`, and it is then granted.
- With `AES_ST_ARB_PKT_CNT_EN`: src0 sends 5 packets and src3 sends 2 → `pkt_cnt[0]=5`, `pkt_cnt[3]=2`, all other counts 0.

Source files
------------

// File: rtl/aes_top_pack.sv
// Shared types and constants for the AES test top: arbiter state encoding,
// datapath widths and the arbiter source-count ceiling.
package aes_top_pack;

    localparam int REG_SIZE          = 32;
    localparam int WORD_COUNTER_SIZE = 16;
    localparam int ARB_MAX_SRC       = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: returns the first requester found when
// searching upward from i_last+1, wrapping modulo N.
module rr_priority_picker
    import aes_top_pack::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] w_try_idx;

    // Walk from the farthest offset back to the nearest so the nearest hit wins.
    always_comb begin
        o_found   = 1'b0;
        o_idx     = '0;
        w_try_idx = '0;
        for (int k = N; k >= 1; k--) begin
            w_try_idx = IDX_W'((int'(i_last) + k) % N);
            if (i_req[w_try_idx]) begin
                o_found = 1'b1;
                o_idx   = w_try_idx;
            end else begin
                o_found = o_found;
            end
        end
    end

endmodule

// File: rtl/aes_st_arbiter.sv
// Packet-locked round-robin arbiter sharing one Avalon-ST sink between NUM_SRC sources.
// Optional per-source packet counters are built when AES_ST_ARB_PKT_CNT_EN is defined.
module aes_st_arbiter
    import aes_top_pack::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = REG_SIZE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC-1:0]          src_sop,
    input  logic [NUM_SRC-1:0]          src_eop,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic                        snk_valid,
    output logic                        snk_sop,
    output logic                        snk_eop,
    output logic [DATA_W-1:0]           snk_data,
    input  logic                        snk_ready,
    output logic [$clog2(NUM_SRC)-1:0]  grant,
    output logic                        busy
`ifdef AES_ST_ARB_PKT_CNT_EN
    ,
    output logic [NUM_SRC*WORD_COUNTER_SIZE-1:0] pkt_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_SRC);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_last_grant;

    logic [NUM_SRC-1:0] w_cand;
    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic               w_locked;
    logic               w_accept;
    logic               w_eop_accept;

    // Only a source opening a packet may win; a stray mid-packet beat is held off.
    assign w_cand       = src_valid & src_sop;
    assign w_locked     = (r_state == LOCKED);
    assign w_accept     = w_locked & src_valid[r_grant] & snk_ready;
    assign w_eop_accept = w_accept & src_eop[r_grant];

    rr_priority_picker #(
        .N     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req   (w_cand),
        .i_last  (r_last_grant),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // Arbitration FSM: lock on a candidate's sop, release on the accepted eop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(NUM_SRC - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_state <= LOCKED;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                LOCKED: begin
                    if (w_eop_accept) begin
                        r_last_grant <= r_grant;
                        r_state      <= IDLE;
                    end else begin
                        r_state <= LOCKED;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Sink is a pass-through of the granted source while locked, quiet otherwise.
    always_comb begin
        src_ready = '0;
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
        snk_data  = '0;
        if (w_locked) begin
            snk_valid          = src_valid[r_grant];
            snk_sop            = src_sop[r_grant];
            snk_eop            = src_eop[r_grant];
            snk_data           = src_data[int'(r_grant)*DATA_W +: DATA_W];
            src_ready[r_grant] = snk_ready;
        end else begin
            src_ready = '0;
        end
    end

    assign grant = r_grant;
    assign busy  = w_locked;

`ifdef AES_ST_ARB_PKT_CNT_EN
    logic [WORD_COUNTER_SIZE-1:0] r_pkt_cnt [NUM_SRC];

    // Per-source completed-packet counters, wrapping naturally at full scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_pkt_cnt[i] <= '0;
            end
        end else if (w_eop_accept) begin
            r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + WORD_COUNTER_SIZE'(1);
        end
    end

    // Flatten counters onto the output bus, source i in slot i.
    always_comb begin
        pkt_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pkt_cnt[i*WORD_COUNTER_SIZE +: WORD_COUNTER_SIZE] = r_pkt_cnt[i];
        end
    end
`else
    // Counters compiled out; arbitration above is unaffected.
`endif

endmodule

// File: tb/tb_aes_st_arbiter.sv
// Directed self-checking bench for aes_st_arbiter (NUM_SRC=4, DATA_W=32).
// Packet-count checks run only when AES_ST_ARB_PKT_CNT_EN is defined.
module tb_aes_st_arbiter;
    import aes_top_pack::*;

    localparam int NS = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NS-1:0]   src_valid, src_sop, src_eop, src_ready;
    logic [NS*DW-1:0] src_data;
    logic            snk_valid, snk_sop, snk_eop, snk_ready, busy;
    logic [DW-1:0]   snk_data;
    logic [1:0]      grant;
`ifdef AES_ST_ARB_PKT_CNT_EN
    logic [NS*WORD_COUNTER_SIZE-1:0] pkt_cnt;
`endif

    aes_st_arbiter #(.NUM_SRC(NS), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (src_valid),
        .src_sop   (src_sop),
        .src_eop   (src_eop),
        .src_data  (src_data),
        .src_ready (src_ready),
        .snk_valid (snk_valid),
        .snk_sop   (snk_sop),
        .snk_eop   (snk_eop),
        .snk_data  (snk_data),
        .snk_ready (snk_ready),
        .grant     (grant),
        .busy      (busy)
`ifdef AES_ST_ARB_PKT_CNT_EN
        ,
        .pkt_cnt   (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Source stimulus state: packets remaining, length, current beat, packet number.
    int          rem [NS];
    int          len [NS];
    int          beat[NS];
    int          pkt [NS];
    bit          nosop [NS];
    bit          fix_en[NS];
    logic [31:0] fix_data[NS];
    logic [NS-1:0] hs;

    function automatic logic [31:0] beat_data(int s, int p, int b);
        return {8'(s), 8'(p), 16'(b)};
    endfunction

    task automatic clear_sources();
        for (int i = 0; i < NS; i++) begin
            rem[i] = 0; len[i] = 1; beat[i] = 0; pkt[i] = 0;
            nosop[i] = 1'b0; fix_en[i] = 1'b0; fix_data[i] = 32'h0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (nosop[i]) begin
                src_valid[i] = 1'b1; src_sop[i] = 1'b0; src_eop[i] = 1'b0;
                src_data[i*DW +: DW] = 32'hDEAD_0000;
            end else if (rem[i] > 0) begin
                src_valid[i] = 1'b1;
                src_sop[i]   = (beat[i] == 0);
                src_eop[i]   = (beat[i] == len[i] - 1);
                src_data[i*DW +: DW] = fix_en[i] ? fix_data[i] : beat_data(i, pkt[i], beat[i]);
            end else begin
                src_valid[i] = 1'b0; src_sop[i] = 1'b0; src_eop[i] = 1'b0;
                src_data[i*DW +: DW] = 32'h0;
            end
        end
    endtask

    task automatic pre();
        drive();
        #1;
    endtask

    task automatic post();
        hs = src_valid & src_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (hs[i]) begin
                if (beat[i] == len[i] - 1) begin
                    beat[i] = 0; pkt[i]++; rem[i]--;
                end else begin
                    beat[i]++;
                end
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        snk_ready = 1'b1;
        clear_sources();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_sources();
        snk_ready = 1'b1;
        rst_n = 1'b0;
        rem[0] = 1; len[0] = 1;
        drive();
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if ({busy, snk_valid, snk_sop, snk_eop, src_ready, grant, snk_data} !== 42'h0) begin
            n_fail++;
            $display("FAIL reset_values: busy=%b v/s/e=%b%b%b rdy=%b grant=%0d data=%h, expected all zero",
                     busy, snk_valid, snk_sop, snk_eop, src_ready, grant, snk_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pre();
        n_checks++;
        if ({snk_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_first_cycle_idle: valid/busy=%b%b, expected 00", snk_valid, busy);
        end
        post();
        pre();
        n_checks++;
        if ({snk_valid, snk_sop, snk_eop, busy, grant, src_ready} !== {4'b1111, 2'd0, 4'b0001}) begin
            n_fail++;
            $display("FAIL reset_first_grant: v/s/e/busy=%b%b%b%b grant=%0d rdy=%b, expected 1111 grant 0 rdy 0001",
                     snk_valid, snk_sop, snk_eop, busy, grant, src_ready);
        end
        n_checks++;
        if (snk_data !== beat_data(0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_first_data: got %h expected %h", snk_data, beat_data(0, 0, 0));
        end
        post();
        pre();
        n_checks++;
        if ({snk_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release_after_eop: valid/busy=%b%b, expected 00", snk_valid, busy);
        end
        post();
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_ctl;
        logic [31:0] exp_d;
        int          g, b, p;
        apply_reset();
        for (int i = 0; i < NS; i++) begin
            rem[i] = 2; len[i] = 3;
        end
        for (int c = 0; c < 20; c++) begin
            pre();
            g = ((c - 1) / 4) % 4;
            b = (c - 1) % 4;
            p = (c - 1) / 16;
            exp_ctl = (c % 4 == 0) ? 4'b0000 : {1'b1, (b == 0), (b == 2), 1'b1};
            n_checks++;
            if ({snk_valid, snk_sop, snk_eop, busy} !== exp_ctl) begin
                n_fail++;
                $display("FAIL rr_ctl cycle %0d: v/s/e/busy=%b%b%b%b expected %b",
                         c, snk_valid, snk_sop, snk_eop, busy, exp_ctl);
            end
            if (c % 4 != 0) begin
                exp_d = beat_data(g, p, b);
                n_checks++;
                if ({grant, snk_data} !== {2'(g), exp_d}) begin
                    n_fail++;
                    $display("FAIL rr_beat cycle %0d: grant=%0d data=%h expected grant %0d data %h",
                             c, grant, snk_data, g, exp_d);
                end
            end else begin
                n_checks++;
                if (src_ready !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL rr_bubble_ready cycle %0d: rdy=%b expected 0000", c, src_ready);
                end
            end
            post();
        end
    endtask

    task automatic test_single_beat();
        apply_reset();
        rem[2] = 1; len[2] = 1; fix_en[2] = 1'b1; fix_data[2] = 32'hA5A5_A5A5;
        pre(); post();
        pre();
        n_checks++;
        if ({snk_valid, snk_sop, snk_eop, busy, grant, src_ready, snk_data} !==
            {4'b1111, 2'd2, 4'b0100, 32'hA5A5_A5A5}) begin
            n_fail++;
            $display("FAIL single_beat: v/s/e/busy=%b%b%b%b grant=%0d rdy=%b data=%h expected 1111 2 0100 a5a5a5a5",
                     snk_valid, snk_sop, snk_eop, busy, grant, src_ready, snk_data);
        end
        post();
        rem[1] = 1; len[1] = 1;
        rem[3] = 1; len[3] = 1;
        pre();
        n_checks++;
        if ({snk_valid, busy, grant} !== {2'b00, 2'd2}) begin
            n_fail++;
            $display("FAIL single_beat_idle_hold: valid/busy=%b%b grant=%0d expected 00 grant 2",
                     snk_valid, busy, grant);
        end
        post();
        pre();
        n_checks++;
        if ({snk_valid, grant, snk_data} !== {1'b1, 2'd3, beat_data(3, 0, 0)}) begin
            n_fail++;
            $display("FAIL single_beat_next_after_2: valid=%b grant=%0d data=%h expected 1 3 %h",
                     snk_valid, grant, snk_data, beat_data(3, 0, 0));
        end
        post();
        pre(); post();
        pre();
        n_checks++;
        if ({snk_valid, grant} !== {1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL single_beat_wrap: valid=%b grant=%0d expected 1 1", snk_valid, grant);
        end
        post();
    endtask

    task automatic test_backpressure();
        apply_reset();
        rem[1] = 1; len[1] = 4;
        rem[3] = 1; len[3] = 2;
        pre(); post();
        pre();
        n_checks++;
        if ({snk_valid, grant, snk_data} !== {1'b1, 2'd1, beat_data(1, 0, 0)}) begin
            n_fail++;
            $display("FAIL bp_first: valid=%b grant=%0d data=%h expected 1 1 %h",
                     snk_valid, grant, snk_data, beat_data(1, 0, 0));
        end
        post();
        snk_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pre();
            n_checks++;
            if ({snk_valid, snk_sop, snk_eop, busy, src_ready, snk_data} !==
                {4'b1001, 4'b0000, beat_data(1, 0, 1)}) begin
                n_fail++;
                $display("FAIL bp_stall %0d: v/s/e/busy=%b%b%b%b rdy=%b data=%h expected 1001 0000 %h",
                         k, snk_valid, snk_sop, snk_eop, busy, src_ready, snk_data, beat_data(1, 0, 1));
            end
            post();
        end
        snk_ready = 1'b1;
        pre();
        n_checks++;
        if ({src_ready, snk_data} !== {4'b0010, beat_data(1, 0, 1)}) begin
            n_fail++;
            $display("FAIL bp_resume: rdy=%b data=%h expected 0010 %h", src_ready, snk_data, beat_data(1, 0, 1));
        end
        post();
        pre();
        n_checks++;
        if (snk_data !== beat_data(1, 0, 2)) begin
            n_fail++;
            $display("FAIL bp_beat2: data=%h expected %h", snk_data, beat_data(1, 0, 2));
        end
        post();
        pre();
        n_checks++;
        if ({snk_valid, snk_sop, snk_eop, busy, snk_data} !== {4'b1011, beat_data(1, 0, 3)}) begin
            n_fail++;
            $display("FAIL bp_eop: v/s/e/busy=%b%b%b%b data=%h expected 1011 %h",
                     snk_valid, snk_sop, snk_eop, busy, snk_data, beat_data(1, 0, 3));
        end
        post();
        pre();
        n_checks++;
        if ({snk_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_bubble: valid/busy=%b%b expected 00", snk_valid, busy);
        end
        post();
        pre();
        n_checks++;
        if ({snk_valid, snk_sop, grant} !== {2'b11, 2'd3}) begin
            n_fail++;
            $display("FAIL bp_next_src: valid/sop=%b%b grant=%0d expected 11 3", snk_valid, snk_sop, grant);
        end
        post();
    endtask

    task automatic test_async_reset();
        apply_reset();
        rem[1] = 1; len[1] = 4;
        pre(); post();
        pre(); post();
        pre();
        n_checks++;
        if ({snk_valid, grant, snk_data} !== {1'b1, 2'd1, beat_data(1, 0, 1)}) begin
            n_fail++;
            $display("FAIL areset_pre: valid=%b grant=%0d data=%h expected 1 1 %h",
                     snk_valid, grant, snk_data, beat_data(1, 0, 1));
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, snk_valid, snk_sop, snk_eop, src_ready, grant, snk_data} !== 42'h0) begin
            n_fail++;
            $display("FAIL areset_immediate: busy=%b v/s/e=%b%b%b rdy=%b grant=%0d data=%h expected all zero",
                     busy, snk_valid, snk_sop, snk_eop, src_ready, grant, snk_data);
        end
        beat[1] = 0;
        drive();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pre();
        n_checks++;
        if ({snk_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL areset_idle_after: valid/busy=%b%b expected 00", snk_valid, busy);
        end
        post();
        pre();
        n_checks++;
        if ({snk_valid, snk_sop, busy, grant, snk_data} !== {3'b111, 2'd1, beat_data(1, 0, 0)}) begin
            n_fail++;
            $display("FAIL areset_resend: v/s/busy=%b%b%b grant=%0d data=%h expected 111 1 %h",
                     snk_valid, snk_sop, busy, grant, snk_data, beat_data(1, 0, 0));
        end
        post();
    endtask

    task automatic test_no_sop();
        apply_reset();
        nosop[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pre();
            n_checks++;
            if ({snk_valid, busy, src_ready} !== 6'b0) begin
                n_fail++;
                $display("FAIL nosop_held %0d: valid/busy=%b%b rdy=%b expected 00 0000",
                         k, snk_valid, busy, src_ready);
            end
            post();
        end
        rem[2] = 1; len[2] = 1;
        pre(); post();
        pre();
        n_checks++;
        if ({snk_valid, grant, snk_data} !== {1'b1, 2'd2, beat_data(2, 0, 0)}) begin
            n_fail++;
            $display("FAIL nosop_other_granted: valid=%b grant=%0d data=%h expected 1 2 %h",
                     snk_valid, grant, snk_data, beat_data(2, 0, 0));
        end
        post();
    endtask

`ifdef AES_ST_ARB_PKT_CNT_EN
    task automatic test_pkt_cnt();
        int exp_cnt[NS] = '{5, 0, 0, 2};
        logic [WORD_COUNTER_SIZE-1:0] got;
        apply_reset();
        rem[0] = 5; len[0] = 1;
        rem[3] = 2; len[3] = 2;
        for (int c = 0; c < 30; c++) begin
            pre(); post();
        end
        for (int i = 0; i < NS; i++) begin
            got = pkt_cnt[i*WORD_COUNTER_SIZE +: WORD_COUNTER_SIZE];
            n_checks++;
            if (got !== WORD_COUNTER_SIZE'(exp_cnt[i])) begin
                n_fail++;
                $display("FAIL pkt_cnt[%0d]: got %0d expected %0d", i, got, exp_cnt[i]);
            end
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        snk_ready = 1'b1;
        src_valid = '0; src_sop = '0; src_eop = '0; src_data = '0;
        hs        = '0;
        clear_sources();
        test_reset();
        test_round_robin();
        test_single_beat();
        test_backpressure();
        test_async_reset();
        test_no_sop();
`ifdef AES_ST_ARB_PKT_CNT_EN
        test_pkt_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
